kf_host_if: RTL
===============

# kf_host_if

Host-side streaming adapter for the Kalman filter core's external interface. It accepts measurement words on a valid/ready input stream and buffers them in a FIFO. For each word it launches one filter run: a single-cycle start pulse, with the word held on the core's data input. Results arrive on the core's AU-done strobe and are collected into an output FIFO, then presented on a valid/ready output stream with a last marker per run.

## Interface
Parameters:
- W, 24, datapath width; matches the core's data and result width.
- IN_DEPTH, 4, input FIFO depth in words (power of 2, ≥2).
- OUT_DEPTH, 8, output FIFO depth in words (power of 2, ≥NRES).
- NRES, 2, AU-done strobes per run (1..OUT_DEPTH).
- TIMEOUT, 1024, maximum cycles per run before abort.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input FIFO can accept a word.
- s_data  in  W  measurement word.
- m_valid  out  1  output FIFO non-empty.
- m_ready  in  1  downstream accepts the word.
- m_data  out  W  head result word.
- m_last  out  1  head word is the final result of its run.
- kf_start  out  1  one-cycle start pulse to the core.
- kf_data_in  out  W  held measurement word driven to the core.
- kf_ready  in  1  core ready for a new run.
- kf_result  in  W  core AU result.
- kf_au_done  in  1  core AU completion strobe.
- busy  out  1  a run is in progress (state ≠ IDLE).
- err_timeout  out  1  sticky flag; a run was aborted on timeout.
- err_clr  in  1  clears err_timeout.

## Operation
**Input FIFO**
- Push on s_valid & s_ready.
- s_ready = !in_full.
- Pop happens only on the IDLE→START transition.

**Output FIFO**
- Entry is {last, W-bit result}.
- Pop on m_valid & m_ready.
- Push on kf_au_done while in START or RUN; kf_au_done in IDLE is ignored.

**State machine: IDLE, START, RUN**
- IDLE→START when all of the following hold:
  - in FIFO is non-empty,
  - kf_ready = 1,
  - out FIFO free slots ≥ NRES. Free slots account for a pop occurring in the same cycle. Reserving NRES slots guarantees no output overflow.
- On the IDLE→START transition, the head input word loads the hold register and the input FIFO pops.
- START: kf_start = 1 for exactly this one cycle; the machine always moves to RUN.
- RUN → IDLE on either condition:
  - the NRES-th counted kf_au_done; that result is pushed with last = 1.
  - the timeout counter reaching TIMEOUT-1; err_timeout is set. Partial results stay in the FIFO, and none of them is marked last.

**Counters**
- Result counter: cleared on entering START; increments on each counted kf_au_done. Strobes in START are counted.
- Timeout counter: cleared on entering START; increments every cycle in START and RUN.

**Hold register and flags**
- kf_data_in = hold register. It keeps its value after a run until the next load.
- err_clr clears err_timeout. If a timeout and err_clr occur in the same cycle, set wins.

## Timing
**Reset values**
- All of the following are 0 on reset: s_ready, m_valid, m_data, m_last, kf_start, kf_data_in, busy, err_timeout.
- Both FIFOs are empty and the state is IDLE.
- s_ready = 1 from the first cycle after rst deasserts.

**Latency**
- A word pushed at edge N is visible in the FIFO at N+1.
- The earliest kf_start is cycle N+2: IDLE evaluates at N+1 and START is entered at edge N+2.
- A kf_au_done sampled at edge M produces m_valid high from cycle M+1 when the output FIFO was empty.

**Handshake rules**
- m_data and m_last are stable while m_valid & !m_ready.
- A simultaneous push and pop on the output FIFO is legal at any occupancy.
- With the input FIFO full, s_ready = 0. A same-cycle pop does not raise s_ready until the next cycle, because s_ready is registered from the count.

**Back-to-back runs**
- kf_start pulses are separated by at least NRES+1 cycles.
- After RUN→IDLE, IDLE needs one cycle to re-evaluate.

**Reset mid-run**
- rst in any state returns to IDLE and empties both FIFOs.
- kf_start deasserts on the next cycle; no partial result is emitted.

**Core signals**
- kf_ready is sampled only in IDLE.
- kf_ready is ignored in START and RUN.

## Test plan
- **Single run.** W=24, NRES=2. Push 0x001000. Core model: kf_ready=1; au_done at +3 with result 0x000111, at +6 with 0x000222.
  - kf_start is a one-cycle pulse two cycles after the push.
  - kf_data_in = 0x001000.
  - Output: 0x000111 (last=0), then 0x000222 (last=1).
- **Input full.** Hold kf_ready=0 and push 5 words with IN_DEPTH=4.
  - s_ready = 0 after the 4th word.
  - The 5th word is not accepted until a run starts.
  - Words then run in FIFO order.
- **Output back-pressure.** OUT_DEPTH=4, NRES=2, m_ready=0, 3 queued inputs.
  - Exactly 2 runs complete; the 3rd kf_start is withheld.
  - m_ready=1 drains 2 words, then the 3rd run starts.
  - No result is lost.
- **Timeout.** TIMEOUT=16 and the core never asserts au_done.
  - Return to IDLE 16 cycles after START; err_timeout = 1.
  - err_clr clears the flag.
  - The next queued word then starts normally.
- **Stray strobe.** kf_au_done pulses in IDLE with result 0xABCDEF → ignored; m_valid stays 0.
- **Reset mid-run.** Assert rst in RUN after 1 of 2 results.
  - All outputs return to reset values and both FIFOs are empty.
  - The first run after reset behaves exactly as in the single-run test.

Source files
------------

// File: rtl/kf_host_if.sv
// Host-side streaming adapter for the Kalman filter core: input FIFO -> one core run per word -> output FIFO.
// Latency: word accepted in cycle N gives kf_start in cycle N+2; a result strobed in cycle M is on m_* in M+1.
// Backpressure: s_ready drops when the input FIFO is full; a run launches only when NRES output slots are free.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   s_valid/s_ready/s_data          measurement input stream
//   m_valid/m_ready/m_data/m_last   result output stream, m_last marks the final result of a run
//   kf_start/kf_data_in             one-cycle start pulse and held measurement word to the core
//   kf_ready/kf_result/kf_au_done   core handshake and result strobe
//   busy, err_timeout, err_clr      run-in-progress status, sticky timeout flag and its clear

module kf_host_if_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DW-1:0]          push_dat_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          head_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    // Caller guarantees no push when full and no pop when empty.
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
endmodule

module kf_host_if #(
    parameter int W         = 24,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 8,
    parameter int NRES      = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         kf_start,
    output logic [W-1:0] kf_data_in,
    input  logic         kf_ready,
    input  logic [W-1:0] kf_result,
    input  logic         kf_au_done,
    output logic         busy,
    output logic         err_timeout,
    input  logic         err_clr
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int RW  = $clog2(NRES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] res_cnt_q, res_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          err_q, err_d;
    logic          s_ready_q, s_ready_d;

    logic          in_push, in_pop;
    logic [W-1:0]  in_head;
    logic [IAW:0]  in_cnt, in_cnt_nxt;
    logic          out_push, out_pop;
    logic [W:0]    out_head;
    logic [OAW:0]  out_cnt;
    logic [OAW+1:0] out_free;

    logic          launch;
    logic          in_run;
    logic          res_counted;
    logic          res_last;
    logic          run_done;
    logic          tmo_abort;

    // ---------------- FIFOs ----------------
    assign in_push    = s_valid && s_ready_q;
    assign in_cnt_nxt = in_cnt + (IAW+1)'(in_push) - (IAW+1)'(in_pop);

    kf_host_if_fifo #(.DW(W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (in_push),
        .push_dat_i (s_data),
        .pop_i      (in_pop),
        .head_dat_o (in_head),
        .count_o    (in_cnt)
    );

    kf_host_if_fifo #(.DW(W + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (out_push),
        .push_dat_i ({res_last, kf_result}),
        .pop_i      (out_pop),
        .head_dat_o (out_head),
        .count_o    (out_cnt)
    );

    assign m_valid = (out_cnt != '0);
    assign out_pop = m_valid && m_ready;
    // Head is masked so an empty FIFO presents zeros rather than stale memory.
    assign m_data  = m_valid ? out_head[W-1:0] : '0;
    assign m_last  = m_valid ? out_head[W]     : 1'b0;

    // Free slots include a pop in this same cycle; reserving NRES slots up front
    // means every strobe of the run has room, so the output FIFO never overflows.
    assign out_free = (OAW+2)'(OUT_DEPTH) - (OAW+2)'(out_cnt) + (OAW+2)'(out_pop);

    // ---------------- run control ----------------
    assign in_run      = (state_q == ST_START) || (state_q == ST_RUN);
    assign launch      = (state_q == ST_IDLE) && (in_cnt != '0) && kf_ready
                         && (out_free >= (OAW+2)'(NRES));
    assign in_pop      = launch;
    // Strobes beyond NRES in a run are dropped so the reservation holds.
    assign res_counted = kf_au_done && in_run && (res_cnt_q < RW'(NRES));
    assign res_last    = (res_cnt_q == RW'(NRES - 1));
    assign out_push    = res_counted;
    // A run with NRES=1 may finish while still in START; RUN then exits at once.
    assign run_done    = (state_q == ST_RUN)
                         && ((res_counted && res_last) || (res_cnt_q == RW'(NRES)));
    assign tmo_abort   = (state_q == ST_RUN) && !run_done
                         && (tmo_cnt_q >= TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (launch) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (run_done || tmo_abort) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        kf_start = (state_q == ST_START);
        busy     = (state_q != ST_IDLE);
    end

    // ---------------- counters, hold register, flags ----------------
    always_comb begin
        res_cnt_d = res_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        hold_d    = hold_q;
        err_d     = err_q;
        if (launch) begin
            res_cnt_d = '0;
            tmo_cnt_d = '0;
            hold_d    = in_head;
        end else begin
            if (res_counted) res_cnt_d = res_cnt_q + RW'(1);
            if (in_run)      tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        // Setting on timeout takes priority over a same-cycle clear.
        if (tmo_abort)    err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        // Registered from the next count, so a pop while full raises s_ready one cycle later.
        s_ready_d = (in_cnt_nxt != (IAW+1)'(IN_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt_q <= '0;
            tmo_cnt_q <= '0;
            hold_q    <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            res_cnt_q <= res_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign kf_data_in  = hold_q;
    assign err_timeout = err_q;
endmodule
